// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall path: mul/div FSM encoding,
// default mul/div latency and the hard-wired zero register.
package hazard_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } md_state_t;

   localparam int unsigned MD_LATENCY_DEFAULT = 32;
   localparam logic [4:0]  REG_ZERO           = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_md_sequencer.sv
// Mul/div sequencer: holds the pipe front for MD_LATENCY cycles after a start,
// then emits a single-cycle done pulse before returning to idle.
module md_sequencer
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
   parameter int unsigned CNT_W      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done
);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d   = CNT_W'(MD_LATENCY - 1);
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         // start still reflects the finishing instruction here, so it is ignored
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      if (!reset) begin
         busy = (state_q == StBusy);
         done = (state_q == StDone);
      end
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush controller for the 5-stage pipe: load-use and branch-operand hazards
// plus mul/div freeze. Optional perf counters under STALL_PERF_COUNT_EN.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [4:0] rtE,
   input  logic [4:0] writeRegisterE,
   input  logic [4:0] writeRegisterM,
   input  logic       regWriteE,
   input  logic       memToRegE,
   input  logic       memToRegM,
   input  logic       branchD,
   input  logic       pcSrcD,
   input  logic       mdStartE,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       flushD,
   output logic       flushE,
   output logic       flushM,
   output logic       mdBusy,
   output logic       mdDone
`ifdef STALL_PERF_COUNT_EN
   ,
   output logic [31:0] stallCycles,
   output logic [15:0] mdOps
`endif
);

   logic lw_stall, br_stall, hz_stall, md_stall_active;
   logic br_from_e, br_from_m;

   md_sequencer #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) u_md_sequencer (
      .clk   (clk),
      .reset (reset),
      .start (mdStartE),
      .busy  (mdBusy),
      .done  (mdDone)
   );

   assign md_stall_active = mdBusy;

   always_comb begin
      lw_stall  = memToRegE && (rtE != REG_ZERO) && ((rtE == rsD) || (rtE == rtD));
      br_from_e = regWriteE && (writeRegisterE != REG_ZERO) &&
                  ((writeRegisterE == rsD) || (writeRegisterE == rtD));
      br_from_m = memToRegM && (writeRegisterM != REG_ZERO) &&
                  ((writeRegisterM == rsD) || (writeRegisterM == rtD));
      br_stall  = branchD && (br_from_e || br_from_m);
      hz_stall  = lw_stall || br_stall;
   end

   // mul/div freeze dominates: E must keep its contents, so no bubbles behind it
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      if (!reset) begin
         stallF = hz_stall || md_stall_active;
         stallD = hz_stall || md_stall_active;
         stallE = md_stall_active;
         flushE = hz_stall && !md_stall_active;
         flushD = pcSrcD && !hz_stall && !md_stall_active;
         flushM = md_stall_active;
      end
   end

`ifdef STALL_PERF_COUNT_EN
   logic [31:0] stall_cycles_q;
   logic [15:0] md_ops_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         md_ops_q       <= '0;
      end else begin
         if (stallF) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (mdDone) md_ops_q       <= md_ops_q + 16'd1;
      end
   end

   assign stallCycles = stall_cycles_q;
   assign mdOps       = md_ops_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized self-checking bench for hazard_stall_controller against a cycle-count
// reference model; directed scenarios cover load-use, branch, mul/div and reset abort.
module tb_hazard_stall_controller;

   localparam int unsigned LAT = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rsD, rtD, rtE, writeRegisterE, writeRegisterM;
   logic       regWriteE, memToRegE, memToRegM, branchD, pcSrcD, mdStartE;
   logic       stallF, stallD, stallE, flushD, flushE, flushM, mdBusy, mdDone;
`ifdef STALL_PERF_COUNT_EN
   logic [31:0] stallCycles;
   logic [15:0] mdOps;
`endif

   int tests_run = 0;
   int fails     = 0;

   // Reference model: remaining busy cycles and a pending done pulse
   int          busy_left = 0;
   bit          done_now  = 0;
   logic [31:0] m_stall_cnt = 0;
   logic [15:0] m_md_ops    = 0;

   always #5 clk = ~clk;

   hazard_stall_controller #(
      .MD_LATENCY (LAT),
      .CNT_W      (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rsD            (rsD),
      .rtD            (rtD),
      .rtE            (rtE),
      .writeRegisterE (writeRegisterE),
      .writeRegisterM (writeRegisterM),
      .regWriteE      (regWriteE),
      .memToRegE      (memToRegE),
      .memToRegM      (memToRegM),
      .branchD        (branchD),
      .pcSrcD         (pcSrcD),
      .mdStartE       (mdStartE),
      .stallF         (stallF),
      .stallD         (stallD),
      .stallE         (stallE),
      .flushD         (flushD),
      .flushE         (flushE),
      .flushM         (flushM),
      .mdBusy         (mdBusy),
      .mdDone         (mdDone)
`ifdef STALL_PERF_COUNT_EN
      ,
      .stallCycles    (stallCycles),
      .mdOps          (mdOps)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_hz();
      bit lw, be, bm;
      lw = memToRegE && rtE != 0 && (rtE == rsD || rtE == rtD);
      be = regWriteE && writeRegisterE != 0 && (writeRegisterE == rsD || writeRegisterE == rtD);
      bm = memToRegM && writeRegisterM != 0 && (writeRegisterM == rsD || writeRegisterM == rtD);
      return lw || (branchD && (be || bm));
   endfunction

   function automatic bit model_stallf();
      return !reset && (model_hz() || busy_left > 0);
   endfunction

   task automatic check_outputs();
      bit hz, bsy, dn, rs;
      rs  = reset;
      hz  = model_hz() && !rs;
      bsy = busy_left > 0 && !rs;
      dn  = done_now && !rs;
      check_eq("stallF", stallF, hz || bsy);
      check_eq("stallD", stallD, hz || bsy);
      check_eq("stallE", stallE, bsy);
      check_eq("flushE", flushE, hz && !bsy);
      check_eq("flushD", flushD, !rs && pcSrcD && !hz && !bsy);
      check_eq("flushM", flushM, bsy);
      check_eq("mdBusy", mdBusy, bsy);
      check_eq("mdDone", mdDone, dn);
`ifdef STALL_PERF_COUNT_EN
      check_eq("stallCycles", stallCycles, m_stall_cnt);
      check_eq("mdOps", {16'd0, mdOps}, {16'd0, m_md_ops});
`endif
   endtask

   // Advance one clock, updating the model with the inputs present at the edge
   task automatic tick();
      bit sf;
      sf = model_stallf();
      @(posedge clk);
      if (reset) begin
         busy_left   = 0;
         done_now    = 0;
         m_stall_cnt = 0;
         m_md_ops    = 0;
      end else begin
         if (sf) m_stall_cnt++;
         if (done_now) m_md_ops++;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) done_now = 1;
         end else if (done_now) begin
            done_now = 0;
         end else if (mdStartE) begin
            busy_left = LAT;
         end
      end
      #1;
   endtask

   task automatic step();
      #2;
      check_outputs();
      tick();
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; rtE = 0; writeRegisterE = 0; writeRegisterM = 0;
      regWriteE = 0; memToRegE = 0; memToRegM = 0; branchD = 0; pcSrcD = 0; mdStartE = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      clear_inputs();
      #1;
      do_reset();
      check_eq("rst_mdBusy", mdBusy, 1'b0);

      // Load-use on rs, then register zero never hazards
      memToRegE = 1; rtE = 8; rsD = 8;
      #2;
      check_eq("lw_stallF", stallF, 1'b1);
      check_eq("lw_flushE", flushE, 1'b1);
      check_eq("lw_flushD", flushD, 1'b0);
      tick();
      rtE = 0; rsD = 0;
      step();
      clear_inputs();

      // Branch on ALU result: stalled first, then resolved and flushed
      branchD = 1; regWriteE = 1; writeRegisterE = 9; rtD = 9; pcSrcD = 1;
      #2;
      check_eq("br_stallD", stallD, 1'b1);
      check_eq("br_flushD_stalled", flushD, 1'b0);
      tick();
      regWriteE = 0; writeRegisterE = 0;
      #2;
      check_eq("br_flushD", flushD, 1'b1);
      tick();
      clear_inputs();

      // Mul/div with a persistent load-use pattern on D
      mdStartE = 1; memToRegE = 1; rtE = 5; rtD = 5;
      step();
      for (int i = 0; i < LAT; i++) begin
         #2;
         check_eq("md_busy_flushE", flushE, 1'b0);
         check_eq("md_busy_stallE", stallE, 1'b1);
         check_outputs();
         tick();
      end
      #2;
      check_eq("md_done_pulse", mdDone, 1'b1);
      check_eq("md_done_restall", flushE, 1'b1);
      tick();
      mdStartE = 0;
      step();
      clear_inputs();

      // Reset in the second BUSY cycle aborts with no done pulse
      mdStartE = 1;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      check_eq("rst_async_stallF", stallF, 1'b0);
      check_eq("rst_async_busy", mdBusy, 1'b0);
      check_outputs();
      tick();
      reset = 1'b0; mdStartE = 0;
      for (int i = 0; i < LAT + 3; i++) step();

`ifdef STALL_PERF_COUNT_EN
      do_reset();
      mdStartE = 1;
      for (int i = 0; i < LAT + 2; i++) step();
      mdStartE = 0; memToRegE = 1; rtE = 3; rsD = 3;
      step();
      clear_inputs();
      #2;
      check_eq("perf_stallCycles", stallCycles, 32'd5);
      check_eq("perf_mdOps", {16'd0, mdOps}, 32'd1);
      tick();
`endif

      // Randomized traffic on small register numbers to provoke collisions
      for (int i = 0; i < 800; i++) begin
         rsD            = 5'($urandom_range(0, 3));
         rtD            = 5'($urandom_range(0, 3));
         rtE            = 5'($urandom_range(0, 3));
         writeRegisterE = 5'($urandom_range(0, 3));
         writeRegisterM = 5'($urandom_range(0, 3));
         regWriteE      = 1'($urandom_range(0, 1));
         memToRegE      = 1'($urandom_range(0, 1));
         memToRegM      = 1'($urandom_range(0, 1));
         branchD        = 1'($urandom_range(0, 1));
         pcSrcD         = 1'($urandom_range(0, 1));
         if (busy_left == 0 && !done_now) mdStartE = ($urandom_range(0, 5) == 0);
         reset          = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
